// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: start/busy/done handshake that loads two operands,
// then steps them LSB-first through a 1-bit full adder for WIDTH cycles.
module bit_serial_add_ctrl #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             sum_bit,
   output logic             sum_bit_valid
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] opa_q, opb_q, sum_q;
   logic             carry_q, cout_q, ovf_q, busy_q, done_q, valid_q;
   logic             s_d, carry_d;

   // Full adder on the current operand LSBs and the carry flip-flop.
   always_comb begin
      s_d     = opa_q[0] ^ opb_q[0] ^ carry_q;
      carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               opa_q   <= a;
               opb_q   <= b;
               carry_q <= cin;
               sum_q   <= '0;
               cnt_q   <= '0;
               valid_q <= 1'b1;
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               carry_q <= carry_d;
               opa_q   <= opa_q >> 1;
               opb_q   <= opb_q >> 1;
               sum_q   <= {s_d, sum_q[WIDTH-1:1]};
               cnt_q   <= cnt_q + CNT_W'(1);
               // Final bit: carry_q is the carry into the MSB, carry_d the carry out.
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign sum           = sum_q;
   assign cout          = cout_q;
   assign ovf           = ovf_q;
   assign sum_bit_valid = valid_q;
   assign sum_bit       = (state_q == S_SHIFT) & s_d;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed and random checks of bit_serial_add_ctrl at WIDTH = 8, 2 and 16.
module tb_bit_serial_add_ctrl;

   logic        clk, rst, cin;
   logic [31:0] a_in, b_in;
   logic        start8, start2, start16;

   logic        busy8, done8, cout8, ovf8, sbit8, valid8;
   logic [7:0]  sum8;
   logic        busy2, done2, cout2, ovf2, sbit2, valid2;
   logic [1:0]  sum2;
   logic        busy16, done16, cout16, ovf16, sbit16, valid16;
   logic [15:0] sum16;

   int checks = 0;
   int errors = 0;

   bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
      .sum_bit(sbit8), .sum_bit_valid(valid8));

   bit_serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2),
      .sum_bit(sbit2), .sum_bit_valid(valid2));

   bit_serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
      .sum_bit(sbit16), .sum_bit_valid(valid16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start one 8-bit add and wait (bounded) for done; lat counts cycles after the start edge.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       output int lat, output int nvalid, output logic [7:0] bits);
      @(negedge clk);
      a_in = 32'(ta); b_in = 32'(tb); cin = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; lat = 1; nvalid = 0; bits = '0;
      while (!done8 && lat < 40) begin
         if (valid8) begin
            if (nvalid < 8) bits[nvalid] = sbit8;
            nvalid++;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic dn(input int w);
      return (w == 2) ? done2 : done16;
   endfunction

   function automatic logic [31:0] sm(input int w);
      return (w == 2) ? 32'(sum2) : 32'(sum16);
   endfunction

   function automatic logic co(input int w);
      return (w == 2) ? cout2 : cout16;
   endfunction

   function automatic logic ov(input int w);
      return (w == 2) ? ovf2 : ovf16;
   endfunction

   // Random operands against a+b+cin computed in 33 bits.
   task automatic sweep(input int w, input int n);
      logic [31:0] mask;
      logic [32:0] tot;
      logic        eovf;
      int          lat;
      mask = (32'h1 << w) - 32'h1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a_in = $urandom & mask;
         b_in = $urandom & mask;
         cin  = 1'($urandom_range(0, 1));
         if (w == 2) start2 = 1'b1; else start16 = 1'b1;
         @(negedge clk);
         start2 = 1'b0; start16 = 1'b0; lat = 1;
         while (!dn(w) && lat < 60) begin
            @(negedge clk);
            lat++;
         end
         tot  = 33'(a_in) + 33'(b_in) + 33'(cin);
         eovf = (a_in[w-1] == b_in[w-1]) && (tot[w-1] != a_in[w-1]);
         check("sweep_lat", 32'(lat), 32'(w + 2));
         check("sweep_sum", sm(w), tot[31:0] & mask);
         check("sweep_cout", 32'(co(w)), 32'(tot[w]));
         check("sweep_ovf", 32'(ov(w)), 32'(eovf));
      end
   endtask

   initial begin
      int         lat, nv, nbusy, ndone, dlat, d1, d2;
      logic [7:0] bits, hs_sum;

      rst = 1'b1; cin = 1'b0; a_in = '0; b_in = '0;
      start8 = 1'b0; start2 = 1'b0; start16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'({busy8, busy2, busy16}), 32'h0);
      check("rst_done", 32'({done8, done2, done16}), 32'h0);
      check("rst_sum8", 32'(sum8), 32'h0);
      check("rst_sum2_16", {14'h0, sum2, sum16}, 32'h0);
      check("rst_cout_ovf", 32'({cout8, ovf8, cout2, ovf2, cout16, ovf16}), 32'h0);
      check("rst_serial", 32'({sbit8, valid8, sbit2, valid2, sbit16, valid16}), 32'h0);
      rst = 1'b0;

      // Basic add
      run8(8'h05, 8'h03, 1'b0, lat, nv, bits);
      check("basic_lat", 32'(lat), 32'd10);
      check("basic_sum", 32'(sum8), 32'h08);
      check("basic_cout_ovf", 32'({cout8, ovf8}), 32'h0);
      check("basic_bits", 32'(bits), 32'h08);
      check("basic_nvalid", 32'(nv), 32'd8);

      // Handshake: extra start pulses and operand changes mid-run
      @(negedge clk);
      a_in = 32'h21; b_in = 32'h42; cin = 1'b0; start8 = 1'b1;
      @(negedge clk);
      nbusy = 0; ndone = 0; dlat = -1; hs_sum = '0;
      for (int l = 1; l <= 16; l++) begin
         if (l == 3 || l == 6) begin
            start8 = 1'b1; a_in = 32'hFF; b_in = 32'hFF;
         end else begin
            start8 = 1'b0;
         end
         if (busy8) nbusy++;
         if (done8) begin
            ndone++; dlat = l; hs_sum = sum8;
         end
         @(negedge clk);
      end
      check("hs_ndone", 32'(ndone), 32'd1);
      check("hs_busy_cycles", 32'(nbusy), 32'd9);
      check("hs_done_lat", 32'(dlat), 32'd10);
      check("hs_sum", 32'(hs_sum), 32'h63);

      // Back-to-back with start held high
      a_in = 32'h10; b_in = 32'h20; cin = 1'b0; start8 = 1'b1;
      @(negedge clk);
      lat = 1; d1 = -1; d2 = -1;
      while (lat < 40 && d2 < 0) begin
         if (done8) begin
            if (d1 < 0) begin
               d1 = lat;
               check("b2b_sum1", 32'(sum8), 32'h30);
               a_in = 32'h01; b_in = 32'h01;
            end else begin
               d2 = lat;
               start8 = 1'b0;
               check("b2b_sum2", 32'(sum8), 32'h02);
            end
         end
         if (d2 < 0) begin
            @(negedge clk);
            lat++;
         end
      end
      start8 = 1'b0;
      check("b2b_first_lat", 32'(d1), 32'd10);
      check("b2b_spacing", 32'(d2 - d1), 32'd10);

      // Carry and overflow corners
      run8(8'hFF, 8'h01, 1'b0, lat, nv, bits);
      check("c1_res", {23'h0, cout8, ovf8, sum8}, {23'h0, 1'b1, 1'b0, 8'h00});
      check("c1_lat", 32'(lat), 32'd10);
      run8(8'h7F, 8'h01, 1'b0, lat, nv, bits);
      check("c2_res", {23'h0, cout8, ovf8, sum8}, {23'h0, 1'b0, 1'b1, 8'h80});
      run8(8'h80, 8'h80, 1'b0, lat, nv, bits);
      check("c3_res", {23'h0, cout8, ovf8, sum8}, {23'h0, 1'b1, 1'b1, 8'h00});
      run8(8'hFF, 8'hFF, 1'b1, lat, nv, bits);
      check("c4_res", {23'h0, cout8, ovf8, sum8}, {23'h0, 1'b1, 1'b0, 8'hFF});
      check("c4_bits", 32'(bits), 32'hFF);

      // Reset during SHIFT cycle 4
      @(negedge clk);
      a_in = 32'hFF; b_in = 32'hFF; cin = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy8), 32'h0);
      check("mid_rst_sum", 32'(sum8), 32'h0);
      check("mid_rst_cout_ovf", 32'({cout8, ovf8}), 32'h0);
      check("mid_rst_serial", 32'({sbit8, valid8}), 32'h0);
      ndone = 0;
      for (int l = 0; l < 12; l++) begin
         if (done8) ndone++;
         @(negedge clk);
      end
      check("mid_rst_no_done", 32'(ndone), 32'd0);
      run8(8'h12, 8'h34, 1'b0, lat, nv, bits);
      check("post_rst_lat", 32'(lat), 32'd10);
      check("post_rst_sum", 32'(sum8), 32'h46);

      sweep(2, 200);
      sweep(16, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
Controller and sequencer for the team's bit-serial adder datapath. It accepts two WIDTH-bit operands and a carry-in on a start/busy/done handshake. It then loads the operand shift registers and steps them LSB-first through a 1-bit full adder with a carry flip-flop for exactly WIDTH cycles, assembling the sum in a right-shifting result register. It sits between the register-file/test driver and the serial datapath, and is the only block that drives load/shift sequencing.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on posedge clk
rst  input  1  reset, synchronous, active-high; clears all state
start  input  1  request to begin an addition; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on the LOAD cycle only
b  input  WIDTH  operand B; captured on the LOAD cycle only
cin  input  1  carry-in; captured on the LOAD cycle only
busy  output  1  high in LOAD and SHIFT states
done  output  1  one-cycle pulse in DONE state; sum/cout/ovf valid
sum  output  WIDTH  result register; holds value until the next LOAD
cout  output  1  final carry-out; holds like sum
ovf  output  1  signed overflow (carry into MSB XOR carry out); holds like sum
sum_bit  output  1  serial sum bit produced this cycle
sum_bit_valid  output  1  high exactly during the WIDTH SHIFT cycles

Behaviour:
- Reset, synchronous: state=IDLE, counter=0, carry FF=0, operand regs=0. Outputs: sum=0, cout=0, ovf=0, busy=0, done=0, sum_bit=0, sum_bit_valid=0. rst overrides start and every other input on the same edge.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 -> LOAD; otherwise stay.
- LOAD, one cycle: capture a, b, cin into opA, opB, carry FF; clear sum to 0; counter=0 -> SHIFT.
- SHIFT, WIDTH cycles, each edge:
  - s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry).
  - opA, opB shift right, zero fill. sum shifts right with s inserted at sum[WIDTH-1].
  - counter++.
  - On the edge where counter==WIDTH-1: ovf <= carry ^ new_carry, cout <= new_carry, then -> DONE.
- Serial outputs: sum_bit = s (combinational from current LSBs and carry), valid only while sum_bit_valid=1. sum_bit=0 outside SHIFT.
- DONE, one cycle: done=1, busy=0. start=1 -> LOAD (back-to-back accepted); else -> IDLE.
- Latency: start sampled at edge T. LOAD occupies cycle T+1, SHIFT occupies T+2..T+WIDTH+1, done=1 in cycle T+WIDTH+2. Total is WIDTH+2 cycles from the start edge to done.
- start while busy=1 is ignored. It is not queued.
- a/b/cin changes outside LOAD have no effect on the in-flight operation.
- sum/cout/ovf are stable from DONE until the next LOAD edge. In LOAD, sum clears to 0, while cout and ovf hold until the final SHIFT edge.
- rst mid-SHIFT: next cycle is IDLE with all outputs at reset values. No done pulse is generated.
- Arithmetic is unsigned modulo 2^WIDTH with carry-out. ovf reports the two's-complement overflow of the same addition.

Test Plan:
- Basic add, WIDTH=8: rst 2 cycles, then start with a=8'h05, b=8'h03, cin=0 -> done exactly 10 cycles after the start edge; sum=8'h08, cout=0, ovf=0. sum_bit LSB-first = 0,0,0,1,0,0,0,0 with sum_bit_valid high 8 cycles.
- Carry and overflow corners:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- Handshake: pulse start again at cycles 3 and 6 of a run, and change a/b mid-run -> single done, result of the original operands. busy high exactly 9 cycles (LOAD + 8 SHIFT).
- Back-to-back: hold start=1 continuously with a=8'h10, b=8'h20, then a=8'h01, b=8'h01 presented at the second LOAD -> done pulses 10 cycles apart. Sums 8'h30 then 8'h02. sum is 8'h30 during the first DONE cycle.
- Reset mid-operation: assert rst for 1 cycle at SHIFT cycle 4 -> next cycle busy=0, sum=0, cout=0, ovf=0, no done. A new start then completes normally.
- Parameter sweep: WIDTH=2 and WIDTH=16 with random operands (≥200 each) versus a reference model of a+b+cin. Check done latency is WIDTH+2 every time.
